// File: rtl/seg_load_unit_pkg.sv
// Shared definitions for segment-register loading: segment selector encoding,
// bus widths, byte-lane encodings and word-address helper.
package seg_load_unit_pkg;

   localparam int unsigned ADDR_W  = 20;
   localparam int unsigned WADDR_W = 19;
   localparam int unsigned DATA_W  = 16;

   // Segment register selector, shared with the segment register file.
   typedef enum logic [1:0] {
      SEG_ES = 2'd0,
      SEG_CS = 2'd1,
      SEG_SS = 2'd2,
      SEG_DS = 2'd3
   } seg_sel_t;

   localparam logic [1:0] BSEL_NONE = 2'b00;
   localparam logic [1:0] BSEL_LO   = 2'b01;
   localparam logic [1:0] BSEL_HI   = 2'b10;
   localparam logic [1:0] BSEL_WORD = 2'b11;

   // Word address of the first (second=0) or following (second=1) word that
   // holds a byte address; the increment wraps modulo 2^19.
   function automatic logic [WADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr,
                                                    input logic              second);
      return byte_addr[ADDR_W-1:1] + {{(WADDR_W-1){1'b0}}, second};
   endfunction

endpackage

// File: rtl/seg_load_unit.sv
// Loads a 16-bit segment register value from word-wide memory, splitting an
// unaligned operand into two byte accesses, then writes it to the register file.
module seg_load_unit
   import seg_load_unit_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         sel,
   input  logic [ADDR_W-1:0]  addr,
   output logic               busy,
   output logic [WADDR_W-1:0] m_addr,
   output logic [1:0]         m_bytesel,
   output logic               m_access,
   input  logic               m_ack,
   input  logic [DATA_W-1:0]  m_data_in,
   output logic               wr_en,
   output logic [1:0]         wr_sel,
   output logic [DATA_W-1:0]  wr_val,
   output logic               complete,
   output logic               ss_loaded
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_LO = 2'd1,
      ACC_HI = 2'd2,
      WRITE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   seg_sel_t            sel_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   val_q;
   logic                unaligned;

   assign unaligned = addr_q[0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // state_nxt unassigned, which would infer a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACC_LO;
         ACC_LO:  if (m_ack) state_nxt = unaligned ? ACC_HI : WRITE;
         ACC_HI:  if (m_ack) state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch and value assembly. m_ack only matters in the access states.
   // NOTE: these datapath registers do not strictly need a reset because every
   // output they feed is gated by state; clearing them keeps simulation X-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q  <= SEG_ES;
         addr_q <= '0;
         val_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sel_q  <= seg_sel_t'(sel);
                  addr_q <= addr;
               end
            end
            ACC_LO: begin
               if (m_ack) begin
                  if (unaligned) val_q <= {8'h00, m_data_in[15:8]};
                  else           val_q <= m_data_in;
               end
            end
            ACC_HI: begin
               if (m_ack) val_q[15:8] <= m_data_in[7:0];
            end
            default: ;
         endcase
      end
   end

   // Outputs decode registered state and latched operands only.
   always_comb begin
      busy      = 1'b0;
      m_access  = 1'b0;
      m_addr    = '0;
      m_bytesel = BSEL_NONE;
      wr_en     = 1'b0;
      wr_sel    = 2'b00;
      wr_val    = '0;
      complete  = 1'b0;
      ss_loaded = 1'b0;
      case (state)
         ACC_LO: begin
            busy      = 1'b1;
            m_access  = 1'b1;
            m_addr    = word_addr(addr_q, 1'b0);
            m_bytesel = unaligned ? BSEL_HI : BSEL_WORD;
         end
         ACC_HI: begin
            busy      = 1'b1;
            m_access  = 1'b1;
            m_addr    = word_addr(addr_q, 1'b1);
            m_bytesel = BSEL_LO;
         end
         WRITE: begin
            busy      = 1'b1;
            wr_en     = 1'b1;
            wr_sel    = sel_q;
            wr_val    = val_q;
            complete  = 1'b1;
            ss_loaded = (sel_q == SEG_SS);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_seg_load_unit.sv
// Directed bench for seg_load_unit: expected write-backs are queued at start and
// compared when the unit writes back; memory-port outputs checked every cycle.
module tb_seg_load_unit;
   import seg_load_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  sel;
   logic [19:0] addr;
   logic        busy;
   logic [18:0] m_addr;
   logic [1:0]  m_bytesel;
   logic        m_access;
   logic        m_ack;
   logic [15:0] m_data_in;
   logic        wr_en;
   logic [1:0]  wr_sel;
   logic [15:0] wr_val;
   logic        complete;
   logic        ss_loaded;

   typedef struct packed {
      logic [1:0]  sel;
      logic [15:0] val;
   } wb_t;

   wb_t sb_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   seg_load_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sel       (sel),
      .addr      (addr),
      .busy      (busy),
      .m_addr    (m_addr),
      .m_bytesel (m_bytesel),
      .m_access  (m_access),
      .m_ack     (m_ack),
      .m_data_in (m_data_in),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_val    (wr_val),
      .complete  (complete),
      .ss_loaded (ss_loaded)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".ctl"}, {busy, m_access, m_bytesel, wr_en, wr_sel, complete, ss_loaded}, 32'h0);
      check({tag, ".m_addr"}, m_addr, 32'h0);
      check({tag, ".wr_val"}, wr_val, 32'h0);
   endtask

   // One access phase: w wait cycles, then ack with d. Ports checked every cycle.
   task automatic access_phase(input string tag, input logic [18:0] wa, input logic [1:0] bs,
                               input int w, input logic [15:0] d, input bit poke_start);
      for (int i = 0; i <= w; i++) begin
         check({tag, ".acc"}, {m_access, busy, wr_en, complete, ss_loaded, wr_val}, {5'b11000, 16'h0});
         check({tag, ".m_addr"}, m_addr, wa);
         check({tag, ".bsel"}, m_bytesel, bs);
         if (poke_start && i == 0) begin
            start = 1'b1;
            sel   = SEG_SS;
            addr  = 20'h55555;
         end else begin
            start = 1'b0;
         end
         m_ack     = (i == w);
         m_data_in = (i == w) ? d : 16'($urandom);
         cyc();
      end
      m_ack     = 1'b0;
      start     = 1'b0;
      m_data_in = 16'($urandom);
   endtask

   task automatic do_load(input string tag, input seg_sel_t s, input logic [19:0] a,
                          input int w_lo, input logic [15:0] d_lo,
                          input int w_hi, input logic [15:0] d_hi, input bit poke_start);
      logic [18:0] wa0;
      logic [18:0] wa1;
      wb_t         exp_wb;
      wb_t         got;
      wa0 = a[19:1];
      wa1 = a[19:1] + 19'd1;
      exp_wb.sel = s;
      exp_wb.val = a[0] ? {d_hi[7:0], d_lo[15:8]} : d_lo;
      sb_q.push_back(exp_wb);

      sel   = s;
      addr  = a;
      start = 1'b1;
      cyc();
      start = 1'b0;
      sel   = 2'($urandom);
      addr  = 20'($urandom);

      access_phase({tag, ".lo"}, wa0, a[0] ? 2'b10 : 2'b11, w_lo, d_lo, poke_start);
      if (a[0]) access_phase({tag, ".hi"}, wa1, 2'b01, w_hi, d_hi, 1'b0);

      check({tag, ".write"}, {wr_en, complete, busy, m_access}, 4'b1110);
      check({tag, ".ss_loaded"}, ss_loaded, (s == SEG_SS));
      check({tag, ".sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         check({tag, ".wr_sel"}, wr_sel, got.sel);
         check({tag, ".wr_val"}, wr_val, got.val);
      end
      cyc();
      check_idle({tag, ".after"});
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      sel       = 2'b00;
      addr      = '0;
      m_ack     = 1'b0;
      m_data_in = '0;
      cyc();
      cyc();
      check_idle("reset");
      reset = 1'b0;

      // Ack with no access outstanding must be ignored.
      m_ack = 1'b1;
      m_data_in = 16'hFFFF;
      cyc();
      check_idle("idle_ack");
      m_ack = 1'b0;

      do_load("aligned",   SEG_DS, 20'h12340, 0, 16'hBEEF, 0, 16'h0000, 1'b0);
      do_load("unaligned", SEG_ES, 20'h00101, 0, 16'hAB00, 0, 16'h00CD, 1'b0);
      do_load("wrap_cs",   SEG_CS, 20'hFFFFF, 0, 16'h34A5, 0, 16'h5A12, 1'b0);
      do_load("wrap_ss",   SEG_SS, 20'hFFFFF, 1, 16'h7700, 2, 16'h0088, 1'b0);
      do_load("waits",     SEG_DS, 20'h0A000, 3, 16'hC0DE, 0, 16'h0000, 1'b1);
      cyc();
      check_idle("waits.no_restart");

      // Reset while in the second access, then a late ack.
      sel   = SEG_SS;
      addr  = 20'h00203;
      start = 1'b1;
      cyc();
      start     = 1'b0;
      m_ack     = 1'b1;
      m_data_in = 16'h1100;
      cyc();
      m_ack = 1'b0;
      check("rst_mid.hi_addr", {m_access, m_bytesel, m_addr}, {1'b1, 2'b01, 19'h00102});
      reset = 1'b1;
      cyc();
      reset     = 1'b0;
      m_ack     = 1'b1;
      m_data_in = 16'h0022;
      check_idle("rst_mid");
      cyc();
      m_ack = 1'b0;
      check_idle("rst_late_ack");

      // Reset takes priority over a simultaneous start.
      reset = 1'b1;
      start = 1'b1;
      sel   = SEG_CS;
      addr  = 20'h00010;
      cyc();
      reset = 1'b0;
      start = 1'b0;
      check_idle("rst_vs_start");

      do_load("post_reset", SEG_ES, 20'h00002, 0, 16'h5A5A, 0, 16'h0000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seg_load_unit.md
SEG_LOAD_UNIT -- requirements
Module: seg_load_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset sampled on clk.
REQ-003 SHALL have port start, input, 1, single-cycle request to load a segment register from memory.
REQ-004 SHALL have port sel, input, 2, target segment register (ES=0, CS=1, SS=2, DS=3).
REQ-005 SHALL have port addr, input, 20, byte-granular physical address of the 16-bit operand.
REQ-006 SHALL have port busy, output, 1, high from the cycle after start acceptance until the cycle after write-back.
REQ-007 SHALL have ports m_addr (output, 19, word address), m_bytesel (output, 2), m_access (output, 1), m_ack (input, 1), m_data_in (input, 16): the word-wide memory read port.
REQ-008 SHALL have ports wr_en (output, 1), wr_sel (output, 2), wr_val (output, 16): the segment register file write port.
REQ-009 SHALL have port complete, output, 1, one-cycle pulse coincident with wr_en.
REQ-010 SHALL have port ss_loaded, output, 1, one-cycle pulse coincident with wr_en when wr_sel==SS (interrupt-inhibit hint).

Function
REQ-011 SHALL implement states IDLE, ACC_LO, ACC_HI, WRITE; IDLE is the reset state.
REQ-012 In IDLE, start==1 SHALL latch sel and addr and move to ACC_LO next cycle; start outside IDLE SHALL be ignored with no side effect.
REQ-013 In ACC_LO: m_access=1, m_addr=addr[19:1]; m_bytesel=2'b11 if addr[0]==0, else 2'b10.
REQ-014 m_access, m_addr, m_bytesel SHALL stay stable until the cycle m_ack==1; data SHALL be sampled in that cycle; m_access SHALL be 0 the following cycle.
REQ-015 Aligned (addr[0]==0): ACC_LO ack SHALL capture full m_data_in as the value and go to WRITE.
REQ-016 Unaligned: ACC_LO ack SHALL capture m_data_in[15:8] as low byte and go to ACC_HI.
REQ-017 ACC_HI: m_addr = addr[19:1]+1 modulo 2^19 (0x7FFFF wraps to 0x00000), m_bytesel=2'b01; ack captures m_data_in[7:0] as high byte, then WRITE.
REQ-018 WRITE SHALL last exactly one cycle: wr_en=1, wr_sel=latched sel, wr_val=assembled value, complete=1, then IDLE.
REQ-019 busy SHALL be 1 in ACC_LO, ACC_HI, WRITE and 0 in IDLE; a start in the cycle after WRITE SHALL be accepted.
REQ-020 m_ack while m_access==0 SHALL be ignored.
REQ-021 Minimum latency start->wr_en: 2 cycles aligned, 3 unaligned (with same-cycle ack); each ack wait cycle adds one.
REQ-022 wr_en, complete, ss_loaded SHALL never be high outside WRITE; wr_val SHALL be 0 when wr_en==0.

Reset
REQ-023 reset SHALL force IDLE on the next edge, taking priority over start and m_ack.
REQ-024 After reset: busy, m_access, m_bytesel, m_addr, wr_en, wr_sel, wr_val, complete, ss_loaded all 0.
REQ-025 Reset mid-access SHALL abort without write-back; a subsequent late m_ack SHALL be ignored.

Structure
REQ-026 The segment-select enum (ES, CS, SS, DS) SHALL live in the shared package, used by this block and the segment register file.
REQ-027 The state enum SHALL be local to seg_load_unit; no sub-module is required.
REQ-028 Outputs SHALL be decoded from registered state and latched operands only; no combinational path from start to memory-port outputs.

Verification
REQ-029 Aligned: start, sel=DS, addr=0x12340, ack same cycle with data 0xBEEF -> one wr_en, wr_sel=3, wr_val=0xBEEF, 2 cycles after start.
REQ-030 Unaligned: sel=ES, addr=0x00101; ack1 data 0xAB00, ack2 data 0x00CD -> m_addr 0x00080 then 0x00081, bytesel 10 then 01, wr_val=0xCDAB.
REQ-031 Wrap: sel=CS, addr=0xFFFFF -> second access m_addr=0x00000, bytesel 01; SS target variant -> ss_loaded pulse with wr_en.
REQ-032 Wait states: aligned, ack delayed 3 cycles -> m_addr/m_bytesel stable throughout, wr_en 5 cycles after start; start during busy ignored.
REQ-033 Reset in ACC_HI, then ack next cycle -> no wr_en, all outputs 0, busy=0; new start afterwards completes normally.
